// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-bus blocks: bus direction, bus
// status and the bus arbiter state encoding.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } rggen_arbiter_state;

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin selector: picks the first set request bit at or
// after the pointer, wrapping around to bit 0. Returns a one-hot grant and
// the binary index of the winner (both zero when nothing requests).
module rggen_round_robin_arbiter #(
  parameter int N = 2,
  localparam int INDEX_WIDTH = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0]           request,
  input  logic [INDEX_WIDTH-1:0] pointer,
  output logic [N-1:0]           grant,
  output logic [INDEX_WIDTH-1:0] grant_index
);

  logic                   hit_upper_s;
  logic                   hit_lower_s;
  logic [INDEX_WIDTH-1:0] index_upper_s;
  logic [INDEX_WIDTH-1:0] index_lower_s;

  // Scan from the top down so the lowest set bit in each half wins: the
  // upper half (at or above the pointer) has priority over the wrapped half.
  always_comb begin
    hit_upper_s   = 1'b0;
    hit_lower_s   = 1'b0;
    index_upper_s = '0;
    index_lower_s = '0;
    for (int j = N - 1; j >= 0; j--) begin
      hit_upper_s   = hit_upper_s | (request[j] & (INDEX_WIDTH'(j) >= pointer));
      hit_lower_s   = hit_lower_s | (request[j] & (INDEX_WIDTH'(j) < pointer));
      index_upper_s = (request[j] && (INDEX_WIDTH'(j) >= pointer)) ? INDEX_WIDTH'(j) : index_upper_s;
      index_lower_s = (request[j] && (INDEX_WIDTH'(j) < pointer))  ? INDEX_WIDTH'(j) : index_lower_s;
    end
  end

  // Merge the two halves into the final index and one-hot grant.
  always_comb begin
    grant_index = '0;
    grant       = '0;
    if (hit_upper_s) begin
      grant_index = index_upper_s;
    end else begin
      grant_index = index_lower_s;
    end
    if (hit_upper_s || hit_lower_s) begin
      grant = {{(N-1){1'b0}}, 1'b1} << grant_index;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one downstream register bus among
// N_REQUESTERS upstream masters. A grant is locked from request until the
// downstream done; a one-cycle GAP afterwards lets the finished requester
// drop its request before the next arbitration.
// Optional feature macro: RGGEN_BUS_ARBITER_TIMEOUT_EN adds a watchdog that
// completes a stuck transaction with SLAVE_ERROR after TIMEOUT_CYCLES.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int N_REQUESTERS   = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQUESTERS-1:0]              s_request,
  input  logic [N_REQUESTERS*ADDRESS_WIDTH-1:0] s_address,
  input  logic [N_REQUESTERS-1:0]              s_direction,
  input  logic [N_REQUESTERS*DATA_WIDTH-1:0]   s_write_data,
  input  logic [N_REQUESTERS*DATA_WIDTH/8-1:0] s_write_strobe,
  output logic [N_REQUESTERS-1:0]              s_done,
  output logic [DATA_WIDTH-1:0]                s_read_data,
  output logic [1:0]                           s_status,
  output logic                                 m_request,
  output logic [ADDRESS_WIDTH-1:0]             m_address,
  output logic                                 m_direction,
  output logic [DATA_WIDTH-1:0]                m_write_data,
  output logic [DATA_WIDTH/8-1:0]              m_write_strobe,
  input  logic                                 m_done,
  input  logic [DATA_WIDTH-1:0]                m_read_data,
  input  logic [1:0]                           m_status
);

  localparam int INDEX_WIDTH  = (N_REQUESTERS > 1) ? $clog2(N_REQUESTERS) : 1;
  localparam int STROBE_WIDTH = DATA_WIDTH / 8;

  rggen_arbiter_state       state_r;
  rggen_arbiter_state       state_next_s;
  logic [INDEX_WIDTH-1:0]   pointer_r;
  logic [INDEX_WIDTH-1:0]   pointer_next_s;
  logic [INDEX_WIDTH-1:0]   grant_r;
  logic [N_REQUESTERS-1:0]  arb_grant_s;
  logic [INDEX_WIDTH-1:0]   arb_index_s;
  logic                     any_request_s;
  logic                     timeout_s;
  logic                     forced_s;
  logic                     complete_s;

  logic                     m_request_r;
  logic [ADDRESS_WIDTH-1:0] m_address_r;
  logic                     m_direction_r;
  logic [DATA_WIDTH-1:0]    m_write_data_r;
  logic [STROBE_WIDTH-1:0]  m_write_strobe_r;

  logic [ADDRESS_WIDTH-1:0] address_s      [N_REQUESTERS];
  logic [DATA_WIDTH-1:0]    write_data_s   [N_REQUESTERS];
  logic [STROBE_WIDTH-1:0]  write_strobe_s [N_REQUESTERS];

  for (genvar i = 0; i < N_REQUESTERS; i++) begin : g_slice
    assign address_s[i]      = s_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign write_data_s[i]   = s_write_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign write_strobe_s[i] = s_write_strobe[i*STROBE_WIDTH +: STROBE_WIDTH];
  end

  rggen_round_robin_arbiter #(
    .N (N_REQUESTERS)
  ) u_round_robin (
    .request     (s_request),
    .pointer     (pointer_r),
    .grant       (arb_grant_s),
    .grant_index (arb_index_s)
  );

  assign any_request_s  = |arb_grant_s;
  assign pointer_next_s = (grant_r == INDEX_WIDTH'(N_REQUESTERS - 1)) ? '0
                        : grant_r + INDEX_WIDTH'(1);

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TIMER_WIDTH-1:0] timeout_count_r;

  assign timeout_s = (state_r == BUSY) &&
                     (timeout_count_r == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Watchdog: zeroed while IDLE so each BUSY starts at 0, counts BUSY cycles without done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_count_r <= '0;
    end else if (state_r == IDLE) begin
      timeout_count_r <= '0;
    end else if ((state_r == BUSY) && !m_done) begin
      timeout_count_r <= timeout_count_r + TIMER_WIDTH'(1);
    end else begin
      timeout_count_r <= timeout_count_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // A real done always wins over the watchdog in the same cycle.
  assign forced_s   = timeout_s && !m_done;
  assign complete_s = (state_r == BUSY) && (m_done || timeout_s);

  // Next-state logic: IDLE -> BUSY on any request, BUSY -> GAP on completion, GAP -> IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_request_s) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (complete_s) begin
          state_next_s = GAP;
        end else begin
          state_next_s = BUSY;
        end
      end
      GAP:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Downstream request registers, grant lock and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_request_r      <= 1'b0;
      m_address_r      <= '0;
      m_direction_r    <= RGGEN_READ;
      m_write_data_r   <= '0;
      m_write_strobe_r <= '0;
      grant_r          <= '0;
      pointer_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_request_s) begin
            m_request_r      <= 1'b1;
            m_address_r      <= address_s[arb_index_s];
            m_direction_r    <= s_direction[arb_index_s];
            m_write_data_r   <= write_data_s[arb_index_s];
            m_write_strobe_r <= write_strobe_s[arb_index_s];
            grant_r          <= arb_index_s;
          end
        end
        BUSY: begin
          if (complete_s) begin
            m_request_r      <= 1'b0;
            m_address_r      <= '0;
            m_direction_r    <= RGGEN_READ;
            m_write_data_r   <= '0;
            m_write_strobe_r <= '0;
            pointer_r        <= pointer_next_s;
          end
        end
        default: begin
          m_request_r <= 1'b0;
        end
      endcase
    end
  end

  // Upstream response: done routed to the locked requester, data/status broadcast.
  always_comb begin
    s_done      = '0;
    s_read_data = m_read_data;
    s_status    = m_status;
    if (complete_s) begin
      s_done = {{(N_REQUESTERS-1){1'b0}}, 1'b1} << grant_r;
    end else begin
      s_done = '0;
    end
    if (forced_s) begin
      s_read_data = '0;
      s_status    = RGGEN_SLAVE_ERROR;
    end else begin
      s_read_data = m_read_data;
      s_status    = m_status;
    end
  end

  assign m_request      = m_request_r;
  assign m_address      = m_address_r;
  assign m_direction    = m_direction_r;
  assign m_write_data   = m_write_data_r;
  assign m_write_strobe = m_write_strobe_r;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Scoreboard bench for rggen_bus_arbiter (N=4). Stimulus pushes expected
// downstream requests and upstream completions; a negedge monitor pops and
// compares them. Define RGGEN_BUS_ARBITER_TIMEOUT_EN to add the watchdog test.
module tb_rggen_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic          dir;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            gap;
  } exp_req_t;

  typedef struct {
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic [1:0]    status;
    int            lat;
  } exp_done_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_request;
  logic [N*AW-1:0] s_address;
  logic [N-1:0]    s_direction;
  logic [N*DW-1:0] s_write_data;
  logic [N*SW-1:0] s_write_strobe;
  logic [N-1:0]    s_done;
  logic [DW-1:0]   s_read_data;
  logic [1:0]      s_status;
  logic            m_request;
  logic [AW-1:0]   m_address;
  logic            m_direction;
  logic [DW-1:0]   m_write_data;
  logic [SW-1:0]   m_write_strobe;
  logic            m_done;
  logic [DW-1:0]   m_read_data;
  logic [1:0]      m_status;

  always #5 clk = ~clk;

  rggen_bus_arbiter #(
    .N_REQUESTERS   (N),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_request      (s_request),
    .s_address      (s_address),
    .s_direction    (s_direction),
    .s_write_data   (s_write_data),
    .s_write_strobe (s_write_strobe),
    .s_done         (s_done),
    .s_read_data    (s_read_data),
    .s_status       (s_status),
    .m_request      (m_request),
    .m_address      (m_address),
    .m_direction    (m_direction),
    .m_write_data   (m_write_data),
    .m_write_strobe (m_write_strobe),
    .m_done         (m_done),
    .m_read_data    (m_read_data),
    .m_status       (m_status)
  );

  int checks = 0;
  int errors = 0;

  exp_req_t  exp_req_q[$];
  exp_done_t exp_done_q[$];

  // requester model: remaining transactions and the access each presents
  int            rem     [N];
  logic [AW-1:0] t_addr  [N];
  logic          t_dir   [N];
  logic [DW-1:0] t_wdata [N];
  logic [SW-1:0] t_strb  [N];

  // downstream slave model
  bit            slave_en;
  int            slave_wait;
  logic [DW-1:0] slave_rdata;
  logic [1:0]    slave_status;
  int            busy_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pending_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  task automatic push_req(input int idx, input int gap);
    exp_req_t e;
    e.addr = t_addr[idx]; e.dir = t_dir[idx]; e.wdata = t_wdata[idx];
    e.strb = t_strb[idx]; e.gap = gap;
    exp_req_q.push_back(e);
  endtask

  task automatic push_done(input int idx, input logic [DW-1:0] rdata,
                           input logic [1:0] status, input int lat);
    exp_done_t e;
    e.done = '0;
    e.done[idx] = 1'b1;
    e.rdata = rdata; e.status = status; e.lat = lat;
    exp_done_q.push_back(e);
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      s_request[i]              = (rem[i] != 0);
      s_address[i*AW +: AW]     = t_addr[i];
      s_direction[i]            = t_dir[i];
      s_write_data[i*DW +: DW]  = t_wdata[i];
      s_write_strobe[i*SW +: SW] = t_strb[i];
    end
  endtask

  // One clock: sample s_done mid-cycle, then update requesters and slave after the edge.
  task automatic tick();
    logic [N-1:0] done_v;
    @(negedge clk);
    done_v = s_done;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (done_v[i] && rem[i] > 0) rem[i]--;
    end
    apply_inputs();
    if (m_request) begin
      busy_cnt++;
      m_done = slave_en && (busy_cnt == slave_wait);
    end else begin
      busy_cnt = 0;
      m_done   = 1'b0;
    end
    m_read_data = slave_rdata;
    m_status    = slave_status;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (pending_total() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("transactions_complete_in_budget", 64'(pending_total() == 0), 64'd1);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT launches a request or signals done.
  initial begin
    logic     prev = 1'b0;
    int       cyc = 0;
    int       last_rise = 0;
    exp_req_t held;
    exp_req_t er;
    exp_done_t ed;
    held = '{addr: '0, dir: 1'b0, wdata: '0, strb: '0, gap: 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b0) begin
        if (m_request && !prev) begin
          check("request_expected", 64'(exp_req_q.size() != 0), 64'd1);
          if (exp_req_q.size() != 0) begin
            er = exp_req_q.pop_front();
            check("m_address", 64'(m_address), 64'(er.addr));
            check("m_direction", 64'(m_direction), 64'(er.dir));
            check("m_write_data", 64'(m_write_data), 64'(er.wdata));
            check("m_write_strobe", 64'(m_write_strobe), 64'(er.strb));
            if (er.gap > 0) check("request_spacing", 64'(cyc - last_rise), 64'(er.gap));
            last_rise = cyc;
            held = er;
          end
        end else if (m_request) begin
          check("hold_address", 64'(m_address), 64'(held.addr));
          check("hold_write_data", 64'(m_write_data), 64'(held.wdata));
          check("hold_strobe", 64'(m_write_strobe), 64'(held.strb));
          check("hold_direction", 64'(m_direction), 64'(held.dir));
        end
        if (s_done != '0) begin
          check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
          if (exp_done_q.size() != 0) begin
            ed = exp_done_q.pop_front();
            check("s_done", 64'(s_done), 64'(ed.done));
            check("s_read_data", 64'(s_read_data), 64'(ed.rdata));
            check("s_status", 64'(s_status), 64'(ed.status));
            check("done_latency", 64'(cyc - last_rise), 64'(ed.lat));
          end
        end
      end
      prev = m_request;
    end
  end

  // Hard stop if something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_request = '0; s_address = '0; s_direction = '0;
    s_write_data = '0; s_write_strobe = '0;
    m_done = 1'b0; m_read_data = '0; m_status = 2'b00;
    slave_en = 1'b1; slave_wait = 1; slave_rdata = '0; slave_status = 2'b00; busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      t_addr[i] = AW'(16'h1000 + 16'(i * 16));
      t_dir[i] = 1'b0;
      t_wdata[i] = 32'hA000_0000 + 32'(i);
      t_strb[i] = 4'b0000;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    check("reset_m_request", 64'(m_request), 64'd0);
    check("reset_m_address", 64'(m_address), 64'd0);
    check("reset_m_direction", 64'(m_direction), 64'd0);
    check("reset_m_write_data", 64'(m_write_data), 64'd0);
    check("reset_m_write_strobe", 64'(m_write_strobe), 64'd0);
    check("reset_s_done", 64'(s_done), 64'd0);

    // contention: all four request, zero-wait slave, order 0,1,2,3,0
    slave_wait = 1; slave_rdata = 32'h5A5A_0000; slave_status = 2'b00;
    push_req(0, 0); push_done(0, 32'h5A5A_0000, 2'b00, 0);
    push_req(1, 3); push_done(1, 32'h5A5A_0000, 2'b00, 0);
    push_req(2, 3); push_done(2, 32'h5A5A_0000, 2'b00, 0);
    push_req(3, 3); push_done(3, 32'h5A5A_0000, 2'b00, 0);
    push_req(0, 3); push_done(0, 32'h5A5A_0000, 2'b00, 0);
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    apply_inputs();
    wait_idle(100);
    repeat (2) tick();

    // single requester read, done on third BUSY cycle
    do_reset();
    t_addr[0] = 16'h0010; t_dir[0] = 1'b0; t_wdata[0] = 32'h0; t_strb[0] = 4'b0000;
    slave_wait = 3; slave_rdata = 32'hDEAD_BEEF; slave_status = 2'b00;
    push_req(0, 0); push_done(0, 32'hDEAD_BEEF, 2'b00, 2);
    rem[0] = 1;
    apply_inputs();
    tick();
    check("m_request_latency", 64'(m_request), 64'd1);
    wait_idle(50);
    check("m_request_low_after_done", 64'(m_request), 64'd0);
    repeat (2) tick();

    // error passthrough on requester 1
    t_addr[1] = 16'h0204; t_dir[1] = 1'b0;
    slave_wait = 2; slave_rdata = 32'h0BAD_C0DE; slave_status = 2'b10;
    push_req(1, 0); push_done(1, 32'h0BAD_C0DE, 2'b10, 1);
    rem[1] = 1;
    apply_inputs();
    wait_idle(50);
    repeat (2) tick();

    // write from requester 2 held across 5 wait cycles
    t_addr[2] = 16'h0100; t_dir[2] = 1'b1; t_wdata[2] = 32'h1234_5678; t_strb[2] = 4'b0011;
    slave_wait = 6; slave_rdata = 32'h0; slave_status = 2'b00;
    push_req(2, 0); push_done(2, 32'h0, 2'b00, 5);
    rem[2] = 1;
    apply_inputs();
    wait_idle(50);
    repeat (2) tick();

    // reset in the middle of requester 3's pending transaction
    t_addr[3] = 16'h0300; t_dir[3] = 1'b0;
    slave_en = 1'b0;
    push_req(3, 0);
    rem[3] = 1;
    apply_inputs();
    repeat (4) tick();
    check("busy_before_reset", 64'(m_request), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_m_request", 64'(m_request), 64'd0);
    check("async_reset_s_done", 64'(s_done), 64'd0);
    check("async_reset_m_address", 64'(m_address), 64'd0);
    t_addr[0] = 16'h0044; t_dir[0] = 1'b0;
    slave_en = 1'b1; slave_wait = 1; slave_rdata = 32'h1111_2222; slave_status = 2'b00;
    push_req(0, 0); push_done(0, 32'h1111_2222, 2'b00, 0);
    push_req(3, 3); push_done(3, 32'h1111_2222, 2'b00, 0);
    rem[0] = 1;
    apply_inputs();
    repeat (2) tick();
    rst = 1'b0;
    wait_idle(50);
    repeat (2) tick();

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    // watchdog: slave never answers; forced SLAVE_ERROR on the 8th BUSY cycle
    t_addr[1] = 16'h0504; t_dir[1] = 1'b0;
    t_addr[2] = 16'h0508; t_dir[2] = 1'b0; t_wdata[2] = 32'h0; t_strb[2] = 4'b0000;
    slave_en = 1'b0; slave_rdata = 32'hCAFE_F00D; slave_status = 2'b00;
    push_req(1, 0);  push_done(1, 32'h0, 2'b10, 7);
    push_req(2, 10); push_done(2, 32'h0, 2'b10, 7);
    rem[1] = 1; rem[2] = 1;
    apply_inputs();
    for (int n = 0; n < 40 && rem[1] != 0; n++) tick();
    check("timeout_first_done", 64'(rem[1]), 64'd0);
    check("timeout_m_request_dropped", 64'(m_request), 64'd0);
    wait_idle(60);
    repeat (2) tick();
`endif

    repeat (3) tick();
    check("request_queue_drained", 64'(exp_req_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one external register bus between N upstream requesters, such as several external-register blocks or a debug port, using round-robin arbitration.
- Sits between the requesters' bus master sides and the single downstream bus slave.
- Locks the grant for one full transaction, from request until done, and routes done, read data and status back to the granted requester only.

Parameters:
N_REQUESTERS, 2, number of upstream requesters (2..16).
ADDRESS_WIDTH, 16, bus address width.
DATA_WIDTH, 32, bus data width (a multiple of 8).
TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
clk  in  1  clock; all logic is clocked on the rising edge.
rst  in  1  reset; the block uses one clock, and reset is asynchronous and active-high.
s_request  in  N  per-requester request, held high until the matching s_done.
s_address  in  N*ADDRESS_WIDTH  per-requester address; requester i occupies slice i.
s_direction  in  N  per-requester direction (rggen_direction, 1 = write).
s_write_data  in  N*DATA_WIDTH  per-requester write data.
s_write_strobe  in  N*DATA_WIDTH/8  per-requester byte strobes.
s_done  out  N  one-hot completion pulse to the granted requester.
s_read_data  out  DATA_WIDTH  read data, broadcast to all requesters; valid with s_done.
s_status  out  2  status (rggen_status), broadcast; valid with s_done.
m_request  out  1  downstream request.
m_address  out  ADDRESS_WIDTH  downstream address.
m_direction  out  1  downstream direction.
m_write_data  out  DATA_WIDTH  downstream write data.
m_write_strobe  out  DATA_WIDTH/8  downstream byte strobes.
m_done  in  1  downstream completion.
m_read_data  in  DATA_WIDTH  downstream read data.
m_status  in  2  downstream status.

Behaviour:
- Reset values: all m_* outputs are 0, m_direction is READ, s_done is 0, state is IDLE, the priority pointer is 0 and grant is 0. Reset applies immediately, including mid-transaction.
- FSM state IDLE:
  - If any s_request bit is high, select the first set bit at or after the pointer, cyclically.
  - Register that requester's address, direction, write data and strobes onto m_*.
  - Set m_request = 1, store grant = index, and go to BUSY.
  - Latency: s_request high in cycle t gives m_request high in cycle t+1.
- FSM state BUSY:
  - m_* are held stable.
  - When m_done is high: s_done[grant] = m_done (combinational), s_read_data = m_read_data and s_status = m_status (pass-through).
  - On that same edge: m_request and all m_* clear to 0, pointer = (grant+1) mod N, and the FSM goes to GAP.
- FSM state GAP (one cycle): no grant is issued, so the previous requester's stale request can fall. The FSM then returns to IDLE.
- m_done is ignored outside BUSY, and s_done is all zeros outside BUSY.
- The s_read_data and s_status pass-through is continuous; requesters qualify it with s_done.
- Fairness: with all N requesting continuously, grants go in the order p, p+1, ..., wrapping. Each requester waits at most N transactions.
- Pointer wrap: a grant at index N-1 gives pointer 0.
- A requester that drops s_request while BUSY does not abort the transaction; the downstream access completes.
- m_done in the same cycle the FSM enters BUSY is legal and completes a zero-wait transaction.
- Minimum per-transaction overhead is 2 cycles (the IDLE-to-BUSY register stage plus GAP).

Optional Feature:
RGGEN_BUS_ARBITER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without m_done.
  - When the count reaches TIMEOUT_CYCLES-1 with no m_done, the block forces s_done[grant] = 1 and s_status = SLAVE_ERROR (2'b10), and s_read_data = 0 for that cycle.
  - m_request and m_* clear, the pointer advances, and the FSM goes to GAP.
  - If m_done arrives in that same cycle, the real m_done response wins.
- Not defined: no counter is built and BUSY waits for m_done indefinitely.

Decomposition:
- rggen_rtl_pkg holds rggen_direction, rggen_status (OKAY = 0, EXOKAY = 1, SLAVE_ERROR = 2, DECODE_ERROR = 3) and the arbiter state enum (IDLE, BUSY, GAP).
- Sub-module rggen_round_robin_arbiter: parameter N; inputs are the request vector and the pointer; outputs are a one-hot grant and the grant index. It is purely combinational and reusable.

Test Plan:
1. Single requester: after reset, s_request[0]=1 with a read at 0x0010, and m_done on the 3rd BUSY cycle with read_data 0xDEADBEEF and OKAY. Expect m_request high 1 cycle after s_request, m_address 0x0010, s_done = 2'b01 with data 0xDEADBEEF, then m_request low.
2. Contention: N=4, all request simultaneously, pointer 0, and each transaction completes on its first BUSY cycle. Expect grant order 0,1,2,3,0, with exactly one GAP cycle between grants.
3. Write path: requester 2 writes 0x12345678 to 0x0100 with strobe 4'b0011. Expect identical values on m_*, held stable across 5 wait cycles, and s_done[2] only.
4. Reset mid-BUSY: assert rst during a pending transaction. Expect m_request=0 and s_done=0 immediately (asynchronous), pointer 0, and a fresh arbitration after release.
5. Error passthrough: m_status = SLAVE_ERROR on m_done. Expect s_status = 2'b10 with s_done[grant].
6. With RGGEN_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert m_done. Expect s_done[grant] with SLAVE_ERROR after 8 BUSY cycles, m_request dropped, and the next requester granted afterward.
